// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// if_stage_pkg : fetch FSM encoding and fetch-path constants.   Rev 1.0
// ============================================================================
package if_stage_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// if_stage_if : instruction-memory req/ack bus.                 Rev 1.0
// ============================================================================
interface if_stage_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : fetch FSM, imem request and IF/ID update strobes. Rev 1.0
// ============================================================================
module fetch_ctrl
    import if_stage_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic start,
    input  wire logic stall,
    input  wire logic mem_stall,
    input  wire logic jump,
    input  wire logic branch,
    input  wire logic eq,
    input  wire logic ack,
    output logic      req,
    output logic      redirect,
    output logic      advance,
    output logic      sel_buf,
    output logic      capture,
    output logic      bubble,
    output logic      drop,
    output logic      faddr_load
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         adv;
    logic         taken;

    assign adv   = start & ~stall & ~mem_stall;
    assign taken = adv & (jump | (branch & eq));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ack is only looked at in REQ/DROP, where req is high, so a stray
    // ack while req is low has no effect.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (taken) begin
                    state_nxt = ack ? ST_REQ : ST_DROP;
                end else if (ack && !adv) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (adv) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                if (ack) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req        = 1'b0;
        redirect   = 1'b0;
        advance    = 1'b0;
        sel_buf    = 1'b0;
        capture    = 1'b0;
        bubble     = 1'b0;
        drop       = 1'b0;
        faddr_load = 1'b0;
        case (state)
            ST_IDLE: begin
                faddr_load = start;
            end
            ST_REQ: begin
                req        = 1'b1;
                redirect   = taken;
                advance    = ack & adv & ~taken;
                bubble     = adv & ~(ack & ~taken);
                capture    = ack & ~adv;
                faddr_load = ack & adv;
            end
            ST_HOLD: begin
                sel_buf    = 1'b1;
                redirect   = taken;
                advance    = adv & ~taken;
                bubble     = taken;
                faddr_load = adv;
            end
            ST_DROP: begin
                // Wrong-path fetch still outstanding: finish it, discard it.
                req        = 1'b1;
                redirect   = taken;
                bubble     = adv;
                drop       = ack;
            end
            default: begin
                req = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : MIPS instruction fetch with PC, holding buffer and IF/ID reg. Rev 1.0
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        start_i,
    input  wire logic        Stall_i,
    input  wire logic        mem_stall_i,
    input  wire logic        Jump_i,
    input  wire logic        Branch_i,
    input  wire logic        Eq_i,
    input  wire logic [31:0] JumpPC_i,
    input  wire logic [31:0] BranchPC_i,
    if_stage_if.master       imem,
    output logic      [31:0] pc_o,
    output logic      [31:0] inst_o
);

    logic        req;
    logic        redirect;
    logic        advance;
    logic        sel_buf;
    logic        capture;
    logic        bubble;
    logic        drop;
    logic        faddr_load;

    logic [31:0] pc;
    logic [31:0] faddr;
    logic [31:0] hold_buf;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic [31:0] pc_nxt;

    fetch_ctrl u_fetch_ctrl (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start      (start_i),
        .stall      (Stall_i),
        .mem_stall  (mem_stall_i),
        .jump       (Jump_i),
        .branch     (Branch_i),
        .eq         (Eq_i),
        .ack        (imem.imem_ack_i),
        .req        (req),
        .redirect   (redirect),
        .advance    (advance),
        .sel_buf    (sel_buf),
        .capture    (capture),
        .bubble     (bubble),
        .drop       (drop),
        .faddr_load (faddr_load)
    );

    assign target = Jump_i ? JumpPC_i : BranchPC_i;
    assign pc_inc = pc_next(pc);
    assign pc_nxt = redirect ? target : (advance ? pc_inc : pc);

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = faddr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // faddr follows the post-update PC so a redirect taken in the same
    // cycle as the completing ack is fetched next.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            faddr <= RESET_PC;
        end else if (faddr_load || drop) begin
            faddr <= pc_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_buf <= NOP_INST;
        end else if (capture) begin
            hold_buf <= imem.imem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_o   <= 32'h0;
            inst_o <= NOP_INST;
        end else if (advance) begin
            pc_o   <= pc_inc;
            inst_o <= sel_buf ? hold_buf : imem.imem_data_i;
        end else if (bubble) begin
            pc_o   <= 32'h0;
            inst_o <= NOP_INST;
        end
    end

endmodule
`default_nettype wire
